// File: rtl/spike_vote_counter.sv
// Per-class spike vote accumulator: sums output spikes per class over a frame and, on frame end,
// runs a sequential argmax to report the winning class and its count.
module spike_vote_counter #(
    parameter int unsigned NUM_OUT   = 250,
    parameter int unsigned NUM_CLASS = 10,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned IDX_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               spike_valid,
    input  logic [NUM_OUT-1:0] spike_in,
    input  logic               frame_done,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [IDX_W-1:0]   class_out,
    output logic [CNT_W-1:0]   max_count,
    output logic               class_valid,
    output logic               busy,
    output logic               overflow
);

    localparam int unsigned      GROUP  = NUM_OUT / NUM_CLASS;
    localparam int unsigned      POP_W  = $clog2(GROUP + 1);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_CLASS - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StArgmax, StResult} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   k_q;
    logic [NUM_OUT-1:0] vec_q;
    logic               pend_q;
    logic               frame_done_q;
    logic [CNT_W-1:0]   cnt_q [NUM_CLASS];
    logic [IDX_W-1:0]   best_idx_q;
    logic [CNT_W-1:0]   best_val_q;

    logic               done_rise;
    logic [GROUP-1:0]   grp_bits;
    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   rd_val;
    logic [POP_W-1:0]   pop;
    logic [CNT_W:0]     sum;
    logic [CNT_W-1:0]   sat_cnt;

    assign done_rise = frame_done & ~frame_done_q;
    assign busy      = (state_q != StIdle);

    // Neuron n lives at spike_in[NUM_OUT-1-n], so class c's group starts at the top of the vector.
    always_comb begin
        grp_bits = '0;
        cur_cnt  = '0;
        rd_val   = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            if (k_q == IDX_W'(c)) begin
                grp_bits = vec_q[NUM_OUT-1-c*GROUP -: GROUP];
                cur_cnt  = cnt_q[c];
            end
            if (rd_idx == IDX_W'(c)) begin
                rd_val = cnt_q[c];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < GROUP; i++) begin
            pop = pop + POP_W'(grp_bits[i]);
        end
    end

    assign sum     = {1'b0, cur_cnt} + (CNT_W+1)'(pop);
    assign sat_cnt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            k_q          <= '0;
            vec_q        <= '0;
            pend_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int c = 0; c < NUM_CLASS; c++) begin
                cnt_q[c] <= '0;
            end
            best_idx_q   <= '0;
            best_val_q   <= '0;
            class_out    <= '0;
            max_count    <= '0;
            class_valid  <= 1'b0;
            overflow     <= 1'b0;
            rd_cnt       <= '0;
        end else begin
            frame_done_q <= frame_done;
            rd_cnt       <= rd_val;
            class_valid  <= 1'b0;
            if (clear) begin
                state_q  <= StIdle;
                pend_q   <= 1'b0;
                overflow <= 1'b0;
                for (int c = 0; c < NUM_CLASS; c++) begin
                    cnt_q[c] <= '0;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // A vector arriving with the frame edge is counted before the argmax.
                        if (spike_valid) begin
                            vec_q   <= spike_in;
                            k_q     <= '0;
                            state_q <= StAccum;
                            if (done_rise) pend_q <= 1'b1;
                        end else if (done_rise || pend_q) begin
                            pend_q  <= 1'b0;
                            k_q     <= '0;
                            state_q <= StArgmax;
                        end
                    end
                    StAccum: begin
                        for (int c = 0; c < NUM_CLASS; c++) begin
                            if (k_q == IDX_W'(c)) cnt_q[c] <= sat_cnt;
                        end
                        k_q <= k_q + 1'b1;
                        if (k_q == LAST_K) state_q <= StIdle;
                        if (spike_valid)   overflow <= 1'b1;
                        if (done_rise)     pend_q   <= 1'b1;
                    end
                    StArgmax: begin
                        // Strict compare keeps the lowest index on ties.
                        if (k_q == '0 || cur_cnt > best_val_q) begin
                            best_idx_q <= k_q;
                            best_val_q <= cur_cnt;
                        end
                        k_q <= k_q + 1'b1;
                        if (k_q == LAST_K) state_q  <= StResult;
                        if (spike_valid)   overflow <= 1'b1;
                    end
                    StResult: begin
                        class_out   <= best_idx_q;
                        max_count   <= best_val_q;
                        class_valid <= 1'b1;
                        for (int c = 0; c < NUM_CLASS; c++) begin
                            cnt_q[c] <= '0;
                        end
                        state_q <= StIdle;
                        if (spike_valid) overflow <= 1'b1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spike_vote_counter.sv
// Bench for spike_vote_counter: directed and random frames checked against a per-class count model.
module tb_spike_vote_counter;

    localparam int NUM_OUT   = 250;
    localparam int NUM_CLASS = 10;
    localparam int GROUP     = 25;
    localparam int CNT_MAX   = 255;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic               spike_valid;
    logic [NUM_OUT-1:0] spike_in;
    logic               frame_done;
    logic [3:0]         rd_idx;
    logic [7:0]         rd_cnt;
    logic [3:0]         class_out;
    logic [7:0]         max_count;
    logic               class_valid;
    logic               busy;
    logic               overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int mcnt [NUM_CLASS];
    int exp_class = 0;
    int exp_max   = 0;

    always #5 clk = ~clk;

    spike_vote_counter #(
        .NUM_OUT  (NUM_OUT),
        .NUM_CLASS(NUM_CLASS),
        .CNT_W    (8),
        .IDX_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .spike_valid(spike_valid),
        .spike_in   (spike_in),
        .frame_done (frame_done),
        .rd_idx     (rd_idx),
        .rd_cnt     (rd_cnt),
        .class_out  (class_out),
        .max_count  (max_count),
        .class_valid(class_valid),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int grp_pop(input logic [NUM_OUT-1:0] v, input int c);
        int s = 0;
        for (int n = c * GROUP; n < (c + 1) * GROUP; n++) s += int'(v[NUM_OUT-1-n]);
        return s;
    endfunction

    task automatic model_add(input logic [NUM_OUT-1:0] v);
        for (int c = 0; c < NUM_CLASS; c++) begin
            mcnt[c] = mcnt[c] + grp_pop(v, c);
            if (mcnt[c] > CNT_MAX) mcnt[c] = CNT_MAX;
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CLASS; c++) mcnt[c] = 0;
    endtask

    task automatic model_best(output int ec, output int em);
        int b = 0;
        for (int c = 1; c < NUM_CLASS; c++) if (mcnt[c] > mcnt[b]) b = c;
        ec = b;
        em = mcnt[b];
    endtask

    function automatic logic [NUM_OUT-1:0] rand_vec(input int sparse);
        logic [255:0] t;
        for (int w = 0; w < 8; w++) begin
            t[w*32 +: 32] = $urandom;
            if (sparse != 0) t[w*32 +: 32] &= $urandom & $urandom;
        end
        return t[NUM_OUT-1:0];
    endfunction

    task automatic send_vec(input logic [NUM_OUT-1:0] v, output int bc);
        spike_in    = v;
        spike_valid = 1'b1;
        tick();
        spike_valid = 1'b0;
        model_add(v);
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin
            bc++;
            tick();
        end
        check("idle_after_vec", 32'(busy), 0);
    endtask

    task automatic rd_check(input string tag, input int idx, input int exp);
        rd_idx = 4'(idx);
        tick();
        check(tag, 32'(rd_cnt), 32'(exp));
    endtask

    task automatic end_frame(input string tag);
        int ec, em, lat;
        model_best(ec, em);
        frame_done = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (class_valid === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        check($sformatf("%s.latency", tag), 32'(lat), 11);
        check($sformatf("%s.class_out", tag), 32'(class_out), 32'(ec));
        check($sformatf("%s.max_count", tag), 32'(max_count), 32'(em));
        tick();
        check($sformatf("%s.cv_pulse", tag), 32'(class_valid), 0);
        frame_done = 1'b0;
        tick();
        model_clear();
        exp_class = ec;
        exp_max   = em;
    endtask

    initial begin
        logic [NUM_OUT-1:0] v;
        int bc, ec, em, pulses, first;

        reset       = 1'b1;
        clear       = 1'b0;
        spike_valid = 1'b0;
        spike_in    = '0;
        frame_done  = 1'b0;
        rd_idx      = '0;
        model_clear();
        tick();
        tick();
        check("rst.class_out", 32'(class_out), 0);
        check("rst.max_count", 32'(max_count), 0);
        check("rst.class_valid", 32'(class_valid), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.overflow", 32'(overflow), 0);
        check("rst.rd_cnt", 32'(rd_cnt), 0);
        reset = 1'b0;
        tick();

        // Neurons 0, 1 (class 0) and 30 (class 1).
        v = '0;
        v[NUM_OUT-1-0]  = 1'b1;
        v[NUM_OUT-1-1]  = 1'b1;
        v[NUM_OUT-1-30] = 1'b1;
        send_vec(v, bc);
        check("t1.accum_cycles", 32'(bc), 10);
        rd_check("t1.rd0", 0, 2);
        rd_check("t1.rd1", 1, 1);
        rd_check("t1.rd_oob", 12, 0);
        end_frame("t1");
        rd_check("t1.rd0_cleared", 0, 0);

        // Class 9 fully active for three ticks.
        v = '0;
        v[GROUP-1:0] = '1;
        for (int t = 0; t < 3; t++) send_vec(v, bc);
        rd_check("t2.rd9", 9, 75);
        end_frame("t2");
        check("t2.class", 32'(class_out), 9);
        check("t2.max", 32'(max_count), 75);
        rd_check("t2.rd9_cleared", 9, 0);

        // Tie between classes 3 and 7.
        v = '0;
        for (int n = 0; n < 4; n++) begin
            v[NUM_OUT-1-(3*GROUP+n)] = 1'b1;
            v[NUM_OUT-1-(7*GROUP+n)] = 1'b1;
        end
        send_vec(v, bc);
        rd_check("t3.rd3", 3, 4);
        rd_check("t3.rd7", 7, 4);
        end_frame("t3");
        check("t3.tie_low", 32'(class_out), 3);

        // Saturation of class 2.
        v = '0;
        for (int n = 2 * GROUP; n < 3 * GROUP; n++) v[NUM_OUT-1-n] = 1'b1;
        for (int t = 0; t < 11; t++) send_vec(v, bc);
        rd_check("t4.rd2_sat", 2, 255);
        end_frame("t4");
        check("t4.max_sat", 32'(max_count), 255);

        // Overflow: second spike_valid while accumulating is dropped.
        v = '0;
        for (int n = GROUP; n < GROUP + 3; n++) v[NUM_OUT-1-n] = 1'b1;
        spike_in    = v;
        spike_valid = 1'b1;
        tick();
        spike_valid = 1'b0;
        model_add(v);
        check("t5.busy", 32'(busy), 1);
        tick();
        spike_in    = '1;
        spike_valid = 1'b1;
        tick();
        spike_valid = 1'b0;
        check("t5.overflow", 32'(overflow), 1);
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin
            bc++;
            tick();
        end
        check("t5.idle", 32'(busy), 0);
        rd_check("t5.rd1", 1, 3);
        rd_check("t5.rd0_dropped", 0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        check("t5.ovf_cleared", 32'(overflow), 0);
        rd_check("t5.rd1_cleared", 1, 0);
        check("t5.class_kept", 32'(class_out), 32'(exp_class));
        check("t5.max_kept", 32'(max_count), 32'(exp_max));

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            int nv;
            nv = 1 + int'($urandom_range(3));
            for (int t = 0; t < nv; t++) begin
                int c;
                send_vec(rand_vec(f % 2), bc);
                c = int'($urandom_range(NUM_CLASS - 1));
                rd_check($sformatf("rand%0d.rd%0d", f, c), c, mcnt[c]);
            end
            end_frame($sformatf("rand%0d", f));
        end

        // Vector and frame edge together, frame_done then held high.
        v = rand_vec(1);
        model_add(v);
        model_best(ec, em);
        spike_in    = v;
        spike_valid = 1'b1;
        frame_done  = 1'b1;
        pulses      = 0;
        first       = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            spike_valid = 1'b0;
            if (class_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = i - 1;
            end
        end
        check("t6.latency", 32'(first), 22);
        check("t6.pulses", 32'(pulses), 1);
        check("t6.class", 32'(class_out), 32'(ec));
        check("t6.max", 32'(max_count), 32'(em));
        frame_done = 1'b0;
        tick();
        model_clear();

        // Reset in the middle of accumulation.
        spike_in    = rand_vec(0);
        spike_valid = 1'b1;
        tick();
        spike_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid.busy", 32'(busy), 0);
        check("rst_mid.class_out", 32'(class_out), 0);
        check("rst_mid.max_count", 32'(max_count), 0);
        tick();
        reset = 1'b0;
        tick();
        check("rst_mid.class_valid", 32'(class_valid), 0);
        rd_check("rst_mid.rd0", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
